run_ctrl: RTL and testbench

//  Run-level sequencer for the program counter and core. Accepts a four-phase req/ack start request

---
 rtl/run_ctrl.sv | 128 ++++++++++++
 tb/tb_run_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// run_ctrl: run-level sequencer between the test harness and prog_counter/core.
// Accepts a four-phase req/ack start request, loads the selected program's base
// address into the PC, enables the core until halt or watchdog expiry, counts
// RUN cycles and reports done with timeout/err status until req is released.
module run_ctrl #(
  parameter int unsigned        PC_W    = 9,
  parameter int unsigned        CNT_W   = 16,
  parameter logic [CNT_W-1:0]   MAX_CYC = 16'hFFFF,
  parameter logic [PC_W-1:0]    BASE0   = 9'd0,
  parameter logic [PC_W-1:0]    BASE1   = 9'd128,
  parameter logic [PC_W-1:0]    BASE2   = 9'd256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [1:0]       prog_sel,
  input  logic             halt,
  output logic             ack,
  output logic             pc_start,
  output logic [PC_W-1:0]  pc_start_addr,
  output logic             core_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             err,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Count value at which the final permitted RUN cycle is executing.
  localparam logic [CNT_W-1:0] WDOG_LAST = MAX_CYC - 1'b1;
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  state_t             state_q;
  logic               ack_q;
  logic               pc_start_q;
  logic [PC_W-1:0]    pc_start_addr_q;
  logic [PC_W-1:0]    base_d;
  logic               timeout_q;
  logic               err_q;
  logic [CNT_W-1:0]   cycle_count_q;

  // Start address for the currently requested program.
  always_comb begin
    base_d = BASE0;
    case (prog_sel)
      2'd0:    base_d = BASE0;
      2'd1:    base_d = BASE1;
      2'd2:    base_d = BASE2;
      default: base_d = BASE0;
    endcase
  end

  // Run sequencer: state, one-cycle handshake pulses and run status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      ack_q           <= 1'b0;
      pc_start_q      <= 1'b0;
      pc_start_addr_q <= '0;
      timeout_q       <= 1'b0;
      err_q           <= 1'b0;
      cycle_count_q   <= '0;
    end else begin
      ack_q      <= 1'b0;
      pc_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            ack_q <= 1'b1;
            if (prog_sel == 2'd3) begin
              // Illegal program: report straight away, PC and counters untouched.
              err_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              pc_start_q      <= 1'b1;
              pc_start_addr_q <= base_d;
              cycle_count_q   <= '0;
              timeout_q       <= 1'b0;
              err_q           <= 1'b0;
              state_q         <= LOAD;
            end
          end
        end
        LOAD: begin
          state_q <= RUN;
        end
        RUN: begin
          if (cycle_count_q != CNT_SAT) begin
            cycle_count_q <= cycle_count_q + 1'b1;
          end
          // Halt takes priority over a watchdog expiry in the same cycle.
          if (halt) begin
            state_q <= DONE;
          end else if (cycle_count_q == WDOG_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (!req) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack           = ack_q;
  assign pc_start      = pc_start_q;
  assign pc_start_addr = pc_start_addr_q;
  assign core_en       = (state_q == RUN);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign timeout       = timeout_q;
  assign err           = err_q;
  assign cycle_count   = cycle_count_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: self-checking bench for run_ctrl. A run-level reference model
// (selected base address, halt position versus watchdog limit) predicts the
// handshake flags and final status of every run, directed and randomized.
module tb_run_ctrl;

  localparam int unsigned PC_W  = 9;
  localparam int unsigned CNT_W = 16;
  localparam int          MAXC  = 8;

  logic             clk;
  logic             reset;
  logic             req;
  logic [1:0]       prog_sel;
  logic             halt;
  logic             ack;
  logic             pc_start;
  logic [PC_W-1:0]  pc_start_addr;
  logic             core_en;
  logic             busy;
  logic             done;
  logic             timeout;
  logic             err;
  logic [CNT_W-1:0] cycle_count;

  int tests;
  int fails;

  // Reference model state: status the DUT must be holding between runs.
  logic [PC_W-1:0]  m_addr;
  logic [CNT_W-1:0] m_count;
  logic             m_to;
  logic             m_err;

  run_ctrl #(
    .PC_W    (PC_W),
    .CNT_W   (CNT_W),
    .MAX_CYC (16'd8),
    .BASE0   (9'd0),
    .BASE1   (9'd128),
    .BASE2   (9'd256)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .prog_sel      (prog_sel),
    .halt          (halt),
    .ack           (ack),
    .pc_start      (pc_start),
    .pc_start_addr (pc_start_addr),
    .core_en       (core_en),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout),
    .err           (err),
    .cycle_count   (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL global_time_limit: simulation did not finish (got running, want finished)");
    $fatal(1, "time limit");
  end

  function automatic logic [PC_W-1:0] base_of(input int sel);
    case (sel)
      1:       return 9'd128;
      2:       return 9'd256;
      default: return 9'd0;
    endcase
  endfunction

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] flags();
    return {ack, pc_start, core_en, busy, done, err};
  endfunction

  task automatic model_reset();
    m_addr  = '0;
    m_count = '0;
    m_to    = 1'b0;
    m_err   = 1'b0;
  endtask

  // One complete run: request, load, execute, done, optional hold, release.
  task automatic run_program(input int sel, input int halt_at, input int hold, input bit wander);
    logic [5:0] exp_f;
    bit fin;
    int k;
    bit halted;
    req      = 1'b1;
    prog_sel = 2'(sel);
    step();
    if (sel == 3) begin
      m_err = 1'b1;
      exp_f = 6'b100111;
      tests++;
      if (flags() !== exp_f) begin
        fails++;
        $display("FAIL err_accept_flags: got %b want %b", flags(), exp_f);
      end
      tests++;
      if (pc_start_addr !== m_addr || cycle_count !== m_count) begin
        fails++;
        $display("FAIL err_holds_status: got addr=%0d cnt=%0d want addr=%0d cnt=%0d",
                 pc_start_addr, cycle_count, m_addr, m_count);
      end
    end else begin
      m_addr  = base_of(sel);
      m_count = '0;
      m_to    = 1'b0;
      m_err   = 1'b0;
      exp_f = 6'b110100;
      tests++;
      if (flags() !== exp_f || pc_start_addr !== m_addr || cycle_count !== '0 || timeout !== 1'b0) begin
        fails++;
        $display("FAIL load_cycle: got flags=%b addr=%0d cnt=%0d to=%b want flags=%b addr=%0d cnt=0 to=0",
                 flags(), pc_start_addr, cycle_count, timeout, exp_f, m_addr);
      end
      step();
      fin = 1'b0;
      k = 1;
      while (!fin && k <= MAXC) begin
        tests++;
        if (flags() !== 6'b001100 || cycle_count !== CNT_W'(k - 1) || pc_start_addr !== m_addr) begin
          fails++;
          $display("FAIL run_cycle_%0d: got flags=%b cnt=%0d addr=%0d want flags=001100 cnt=%0d addr=%0d",
                   k, flags(), cycle_count, pc_start_addr, k - 1, m_addr);
        end
        halt = (k == halt_at);
        if (wander) begin
          prog_sel = 2'($urandom_range(0, 3));
          if (k == 2) req = 1'b0;
        end
        step();
        halt = 1'b0;
        if (k == halt_at || k == MAXC) fin = 1'b1;
        k++;
      end
      halted  = (halt_at >= 1 && halt_at <= MAXC);
      m_count = halted ? CNT_W'(halt_at) : CNT_W'(MAXC);
      m_to    = !halted;
      tests++;
      if (flags() !== 6'b000110 || cycle_count !== m_count || timeout !== m_to || pc_start_addr !== m_addr) begin
        fails++;
        $display("FAIL run_done: got flags=%b cnt=%0d to=%b addr=%0d want flags=000110 cnt=%0d to=%b addr=%0d",
                 flags(), cycle_count, timeout, pc_start_addr, m_count, m_to, m_addr);
      end
    end
    exp_f = {5'b00011, m_err};
    if (req) begin
      for (int i = 0; i < hold; i++) begin
        halt     = 1'($urandom_range(0, 1));
        prog_sel = 2'($urandom_range(0, 3));
        step();
        tests++;
        if (flags() !== exp_f || cycle_count !== m_count || pc_start_addr !== m_addr) begin
          fails++;
          $display("FAIL done_hold_%0d: got flags=%b cnt=%0d addr=%0d want flags=%b cnt=%0d addr=%0d",
                   i, flags(), cycle_count, pc_start_addr, exp_f, m_count, m_addr);
        end
      end
    end
    req  = 1'b0;
    halt = 1'($urandom_range(0, 1));
    step();
    halt = 1'b0;
    exp_f = {5'b00000, m_err};
    tests++;
    if (flags() !== exp_f || cycle_count !== m_count || pc_start_addr !== m_addr) begin
      fails++;
      $display("FAIL release_idle: got flags=%b cnt=%0d addr=%0d want flags=%b cnt=%0d addr=%0d",
               flags(), cycle_count, pc_start_addr, exp_f, m_count, m_addr);
    end
    if (sel != 3) begin
      tests++;
      if (timeout !== m_to) begin
        fails++;
        $display("FAIL release_timeout_held: got %b want %b", timeout, m_to);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 1'b1;
    prog_sel = 2'd1;
    halt  = 1'b1;
    step();
    step();
    model_reset();
    tests++;
    if ({flags(), timeout} !== 7'b0 || pc_start_addr !== '0 || cycle_count !== '0) begin
      fails++;
      $display("FAIL reset_values: got flags=%b to=%b addr=%0d cnt=%0d want all zero",
               flags(), timeout, pc_start_addr, cycle_count);
    end
    req   = 1'b0;
    halt  = 1'b0;
    reset = 1'b0;
    step();
    tests++;
    if (flags() !== 6'b0) begin
      fails++;
      $display("FAIL reset_release_idle: got flags=%b want 000000", flags());
    end
  endtask

  task automatic test_basic_halt();
    run_program(1, 5, 10, 1'b0);
  endtask

  task automatic test_watchdog();
    run_program(0, 0, 2, 1'b0);
    run_program(0, MAXC, 1, 1'b0);
    run_program(2, MAXC - 1, 0, 1'b0);
    run_program(1, 1, 0, 1'b0);
  endtask

  task automatic test_illegal_sel();
    run_program(3, 0, 3, 1'b0);
    run_program(2, 3, 0, 1'b0);
  endtask

  task automatic test_reset_in_run();
    int sel;
    sel = $urandom_range(0, 2);
    req = 1'b1;
    prog_sel = 2'(sel);
    step();
    step();
    step();
    step();
    tests++;
    if (flags() !== 6'b001100 || cycle_count !== 16'd2) begin
      fails++;
      $display("FAIL pre_reset_run3: got flags=%b cnt=%0d want flags=001100 cnt=2", flags(), cycle_count);
    end
    reset = 1'b1;
    req   = 1'b0;
    step();
    reset = 1'b0;
    model_reset();
    tests++;
    if ({flags(), timeout} !== 7'b0 || pc_start_addr !== '0 || cycle_count !== '0) begin
      fails++;
      $display("FAIL reset_in_run: got flags=%b to=%b addr=%0d cnt=%0d want all zero",
               flags(), timeout, pc_start_addr, cycle_count);
    end
    run_program(2, $urandom_range(1, 10), 1, 1'b0);
  endtask

  task automatic test_wander_and_idle_halt();
    run_program(1, 4, 0, 1'b1);
    run_program(0, 0, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      halt = 1'b1;
      prog_sel = 2'($urandom_range(0, 3));
      step();
      tests++;
      if (flags() !== {5'b0, m_err} || cycle_count !== m_count) begin
        fails++;
        $display("FAIL halt_in_idle_%0d: got flags=%b cnt=%0d want flags=%b cnt=%0d",
                 i, flags(), cycle_count, {5'b0, m_err}, m_count);
      end
    end
    halt = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      run_program($urandom_range(0, 3), $urandom_range(0, 10), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    req = 1'b0;
    prog_sel = 2'd0;
    halt = 1'b0;
    model_reset();
    test_reset();
    test_basic_halt();
    test_watchdog();
    test_illegal_sel();
    test_reset_in_run();
    test_wander_and_idle_halt();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
